// File: rtl/pulse_sched.sv
// Multi-channel timed pulse scheduler. Each channel buffers timestamped
// commands in its own FIFO. A channel issues its head command once the internal
// qclk reaches the head's timestamp. A command that issues after its timestamp
// sets a sticky late flag for that channel.
module pulse_sched #(
  parameter int unsigned N_CHANNELS    = 4,
  parameter int unsigned CHAN_ID_WIDTH = 2,
  parameter int unsigned CMD_WIDTH     = 72,
  parameter int unsigned TIME_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [CHAN_ID_WIDTH-1:0]                       in_chan,
  input  logic [TIME_WIDTH-1:0]                          in_time,
  input  logic [CMD_WIDTH-1:0]                           in_cmd,
  input  logic                                           qclk_load_en,
  input  logic [TIME_WIDTH-1:0]                          qclk_load_val,
  output logic [TIME_WIDTH-1:0]                          qclk_out,
  input  logic                                           flush,
  input  logic                                           err_clr,
  output logic [N_CHANNELS*CMD_WIDTH-1:0]                cmd_out,
  output logic [N_CHANNELS-1:0]                          cstrobe_out,
  output logic [N_CHANNELS-1:0]                          late_err,
  output logic                                           empty,
  output logic [N_CHANNELS*($clog2(FIFO_DEPTH)+1)-1:0]   fill
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FillW = PtrW + 1;

  logic [TIME_WIDTH-1:0] qclk_q, qclk_d;

  // Pointers carry one wrap bit above the address bits.
  logic [FillW-1:0]      wr_ptr_q [N_CHANNELS];
  logic [FillW-1:0]      rd_ptr_q [N_CHANNELS];
  logic [TIME_WIDTH-1:0] time_mem [N_CHANNELS][FIFO_DEPTH];
  logic [CMD_WIDTH-1:0]  cmd_mem  [N_CHANNELS][FIFO_DEPTH];

  logic [N_CHANNELS-1:0] full, ch_empty, push, fire, late;
  logic [TIME_WIDTH-1:0] diff     [N_CHANNELS];
  logic [CMD_WIDTH-1:0]  head_cmd [N_CHANNELS];
  logic                  sel_full, chan_ok;

  logic [N_CHANNELS-1:0] strobe_q, late_q;
  logic [CMD_WIDTH-1:0]  cmd_q [N_CHANNELS];

  // qclk next state: load overrides the free-running increment.
  always_comb begin
    qclk_d = qclk_q + TIME_WIDTH'(1);
    if (qclk_load_en) qclk_d = qclk_load_val;
  end

  // qclk register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) qclk_q <= '0;
    else       qclk_q <= qclk_d;
  end

  // Per-channel FIFO status and issue decision on the head entry.
  always_comb begin
    full     = '0;
    ch_empty = '0;
    fire     = '0;
    late     = '0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      full[i]     = (wr_ptr_q[i][PtrW] != rd_ptr_q[i][PtrW]) &&
                    (wr_ptr_q[i][PtrW-1:0] == rd_ptr_q[i][PtrW-1:0]);
      ch_empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      diff[i]     = time_mem[i][rd_ptr_q[i][PtrW-1:0]] - qclk_q;
      head_cmd[i] = cmd_mem[i][rd_ptr_q[i][PtrW-1:0]];
      // Modular difference: zero is on time, negative (MSB set) is late.
      fire[i]     = !flush && !ch_empty[i] &&
                    ((diff[i] == '0) || diff[i][TIME_WIDTH-1]);
      late[i]     = fire[i] && (diff[i] != '0);
    end
  end

  // Push handshake; out-of-range channels are never ready.
  always_comb begin
    sel_full = 1'b0;
    chan_ok  = 1'b0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      if (32'(in_chan) == i) begin
        chan_ok  = 1'b1;
        sel_full = full[i];
      end
    end
    in_ready = !flush && chan_ok && !sel_full;
    push     = '0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      push[i] = in_valid && in_ready && (32'(in_chan) == i);
    end
  end

  // FIFO storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      if (push[i]) begin
        time_mem[i][wr_ptr_q[i][PtrW-1:0]] <= in_time;
        cmd_mem[i][wr_ptr_q[i][PtrW-1:0]]  <= in_cmd;
      end
    end
  end

  // Pointers, issue strobes, issued payloads and sticky late flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q <= '0;
      late_q   <= '0;
      for (int unsigned i = 0; i < N_CHANNELS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cmd_q[i]    <= '0;
      end
    end else begin
      strobe_q <= fire;
      // A late issue in the same cycle as err_clr keeps the flag set.
      late_q   <= (late_q & ~{N_CHANNELS{err_clr}}) | late;
      for (int unsigned i = 0; i < N_CHANNELS; i++) begin
        if (fire[i]) cmd_q[i] <= head_cmd[i];
        if (flush) begin
          wr_ptr_q[i] <= '0;
          rd_ptr_q[i] <= '0;
        end else begin
          if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + FillW'(1);
          if (fire[i]) rd_ptr_q[i] <= rd_ptr_q[i] + FillW'(1);
        end
      end
    end
  end

  // Output packing.
  always_comb begin
    cmd_out = '0;
    fill    = '0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      cmd_out[i*CMD_WIDTH +: CMD_WIDTH] = cmd_q[i];
      fill[i*FillW +: FillW]            = wr_ptr_q[i] - rd_ptr_q[i];
    end
  end

  assign qclk_out    = qclk_q;
  assign cstrobe_out = strobe_q;
  assign late_err    = late_q;
  assign empty       = &ch_empty;

endmodule

// File: tb/tb_pulse_sched.sv
// Directed bench for pulse_sched: expected issues are queued when commands are
// pushed and matched against strobes as they appear; qclk is tracked by a model.
module tb_pulse_sched;
  localparam int NC = 4;
  localparam int CW = 72;
  localparam int TW = 32;
  localparam int FD = 8;
  localparam int FW = 4;

  logic            clk, reset;
  logic            in_valid, in_ready;
  logic [1:0]      in_chan;
  logic [TW-1:0]   in_time;
  logic [CW-1:0]   in_cmd;
  logic            qclk_load_en;
  logic [TW-1:0]   qclk_load_val, qclk_out;
  logic            flush, err_clr;
  logic [NC*CW-1:0] cmd_out;
  logic [NC-1:0]   cstrobe_out, late_err;
  logic            empty;
  logic [NC*FW-1:0] fill;

  pulse_sched #(
    .N_CHANNELS   (NC),
    .CHAN_ID_WIDTH(2),
    .CMD_WIDTH    (CW),
    .TIME_WIDTH   (TW),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_chan      (in_chan),
    .in_time      (in_time),
    .in_cmd       (in_cmd),
    .qclk_load_en (qclk_load_en),
    .qclk_load_val(qclk_load_val),
    .qclk_out     (qclk_out),
    .flush        (flush),
    .err_clr      (err_clr),
    .cmd_out      (cmd_out),
    .cstrobe_out  (cstrobe_out),
    .late_err     (late_err),
    .empty        (empty),
    .fill         (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          chan;
    logic [71:0] cmd;
    logic [31:0] q;
    logic        late;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_q;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Match every strobe against the oldest queued expectation of its channel.
  task automatic scan();
    for (int c = 0; c < NC; c++) begin
      if (cstrobe_out[c]) begin
        int idx = -1;
        for (int k = 0; k < sb.size(); k++) if (idx < 0 && sb[k].chan == c) idx = k;
        if (idx < 0) begin
          chk($sformatf("unexpected_strobe_ch%0d", c), cstrobe_out[c], 0);
        end else begin
          chk($sformatf("cmd_ch%0d", c), cmd_out[c*CW +: CW], sb[idx].cmd);
          chk($sformatf("fire_qclk_ch%0d", c), qclk_out, sb[idx].q);
          if (sb[idx].late) chk($sformatf("late_ch%0d", c), late_err[c], 1);
          sb.delete(idx);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_q = qclk_load_en ? qclk_load_val : model_q + 1;
    #1;
    chk("qclk", qclk_out, model_q);
    scan();
  endtask

  task automatic push(input int ch, input logic [31:0] t, input logic [71:0] cmd,
                      input bit exp_rdy, input bit track, input logic [31:0] exp_q,
                      input bit exp_late);
    in_valid = 1'b1;
    in_chan  = ch[1:0];
    in_time  = t;
    in_cmd   = cmd;
    #1;
    chk($sformatf("in_ready_ch%0d", ch), in_ready, exp_rdy);
    if (track) sb.push_back('{ch, cmd, exp_q, exp_late});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] v);
    qclk_load_en  = 1'b1;
    qclk_load_val = v;
    tick();
    qclk_load_en  = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && sb.size() > 0; n++) tick();
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_chan = '0; in_time = '0; in_cmd = '0;
    qclk_load_en = 1'b0; qclk_load_val = '0; flush = 1'b0; err_clr = 1'b0;
    model_q = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_qclk", qclk_out, 0);
    chk("rst_empty", empty, 1);
    chk("rst_fill", fill, 0);
    chk("rst_strobe", cstrobe_out, 0);
    chk("rst_cmd", cmd_out, 0);
    chk("rst_late", late_err, 0);
    reset = 1'b0;
    model_q = '0;

    // Single on-time command: strobe at T+1.
    load(32'd5);
    push(0, 32'd20, 72'hA5, 1, 1, 32'd21, 0);
    drain(40);
    chk("t1_empty", empty, 1);
    chk("t1_late", late_err, 0);

    // Two channels with the same time, then a backward qclk load.
    load(32'd0);
    push(1, 32'd10, 72'h11, 1, 1, 32'd11, 0);
    push(2, 32'd10, 72'h22, 1, 1, 32'd11, 0);
    load(32'd0);
    drain(30);

    // Back-to-back same-time commands: second is late.
    load(32'd0);
    push(0, 32'd30, 72'h31, 1, 1, 32'd31, 0);
    push(0, 32'd30, 72'h32, 1, 1, 32'd32, 1);
    drain(50);
    chk("t3_late_set", late_err, 4'b0001);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_late_clr", late_err, 4'b0000);

    // Fill channel 3 to capacity.
    for (int n = 0; n < FD; n++) push(3, 32'd1000, 72'(n), 1, 0, 0, 0);
    chk("t4_fill3", fill[3*FW +: FW], FD);
    in_chan = 2'd3;
    #1;
    chk("t4_ready3_full", in_ready, 0);
    in_chan = 2'd0;
    #1;
    chk("t4_ready0", in_ready, 1);
    push(3, 32'd1000, 72'hEE, 0, 0, 0, 0);
    chk("t4_fill3_after9", fill[3*FW +: FW], FD);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_flushed", fill, 0);

    // Flush with a simultaneous push request.
    for (int n = 0; n < 3; n++) push(2, 32'd1000, 72'(n), 1, 0, 0, 0);
    chk("t5_fill2", fill[2*FW +: FW], 3);
    flush = 1'b1; in_valid = 1'b1; in_chan = 2'd2; in_time = 32'd1000; in_cmd = 72'h5;
    #1;
    chk("t5_ready_flush", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_fill", fill, 0);
    chk("t5_empty", empty, 1);
    chk("t5_strobe", cstrobe_out, 0);
    tick();
    chk("t5_strobe2", cstrobe_out, 0);

    // qclk wrap, then a late command, then asynchronous reset while pending.
    load(32'hFFFF_FFFE);
    push(1, 32'd1, 72'h77, 1, 1, 32'd2, 0);
    drain(10);
    chk("t6_wrap_late", late_err, 0);
    push(3, 32'd0, 72'h99, 1, 1, model_q + 32'd2, 1);
    drain(5);
    chk("t6_late3", late_err, 4'b1000);
    push(0, model_q + 32'd100, 72'h55, 1, 0, 0, 0);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_rst_qclk", qclk_out, 0);
    chk("t6_rst_fill", fill, 0);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_strobe", cstrobe_out, 0);
    chk("t6_rst_cmd", cmd_out, 0);
    chk("t6_rst_late", late_err, 0);
    #20;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_q = '0;
    repeat (3) tick();
    chk("t6_post_fill", fill, 0);
    chk("t6_post_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
